rcu_freelist_ctrl: RTL
======================

Name: rcu_freelist_ctrl

Overview:
- Sequencing controller for the 2-wide physical-register freelist FIFO in the RCU.
- Gates rename-side allocation so it only proceeds when the freelist holds enough entries.
- Forwards commit-side reclaims: old physical registers are written back, and the exception-recovery read pointer is advanced.
- Runs the exception-recovery sequence: a one-cycle freelist excep_rst, then a fixed settle window during which rename is blocked.

Parameters:
- FL_SIZE, 31: freelist depth, with p0 excluded.
- FL_SIZE_WIDTH, 5: pointer width. fl_num_i is FL_SIZE_WIDTH+1 bits.
- PREG_WIDTH, 6: physical register index width.
- RECOVER_CYCLES, 2: settle cycles after excep_rst before rename resumes. Legal range 1..15.
- STALL_CNT_WIDTH, 16: width of the saturating stall counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- rename_valid_i  in  1  rename bundle valid.
- rename_need_first_i  in  1  slot0 has rd != x0.
- rename_need_second_i  in  1  slot1 has rd != x0.
- rename_ready_o  out  1  bundle accepted when valid & ready.
- fl_num_i  in  FL_SIZE_WIDTH+1  current freelist occupancy.
- fl_rd_first_en_o  out  1  freelist rd_first_en.
- fl_rd_second_en_o  out  1  freelist rd_second_en.
- commit_valid_first_i  in  1  slot0 commits.
- commit_valid_second_i  in  1  slot1 commits.
- commit_has_rd_first_i  in  1  slot0 releases an old preg.
- commit_has_rd_second_i  in  1  slot1 releases an old preg.
- commit_old_prd_first_i  in  PREG_WIDTH  old preg for slot0.
- commit_old_prd_second_i  in  PREG_WIDTH  old preg for slot1.
- fl_wr_first_en_o  out  1  freelist wr_first_en.
- fl_wr_second_en_o  out  1  freelist wr_second_en.
- fl_wdata_first_o  out  PREG_WIDTH  freelist wdata_first.
- fl_wdata_second_o  out  PREG_WIDTH  freelist wdata_second.
- fl_rd_excep_first_en_o  out  1  freelist rd_excep_first_en.
- fl_rd_excep_second_en_o  out  1  freelist rd_excep_second_en.
- exception_i  in  1  one-cycle pulse from ROB at the excepting commit.
- fl_excep_rst_o  out  1  freelist excep_rst_i.
- recover_busy_o  out  1  recovery in progress.
- stall_cnt_o  out  STALL_CNT_WIDTH  count of freelist-starved cycles.
- err_o  out  1  sticky overflow/underflow flag.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; settle counter=0.
  - stall_cnt_o=0; err_o=0.
  - Outputs derived combinationally from that state: rename_ready_o, fl_excep_rst_o and recover_busy_o are all 0. All enable outputs are 0 while inputs are 0.
  - rst overrides everything, including mid-recovery.
- FSM states: IDLE, FLUSH, SETTLE.
  - IDLE + exception_i -> FLUSH.
  - FLUSH -> SETTLE, with settle counter loaded to RECOVER_CYCLES-1.
  - SETTLE: counter decrements. At counter==0 -> IDLE.
  - exception_i in FLUSH or SETTLE -> FLUSH. The sequence restarts.
- fl_excep_rst_o = (state==FLUSH). It is high for exactly one cycle per sequence.
- recover_busy_o = (state!=IDLE).
- Allocation:
  - need = rename_need_first_i + rename_need_second_i, giving 0..2.
  - rename_ready_o = (state==IDLE) & !exception_i & (fl_num_i >= need).
  - fire = rename_valid_i & rename_ready_o.
  - fl_rd_first_en_o = fire & need_first.
  - fl_rd_second_en_o = fire & need_second. This holds even when need_first=0; the freelist then returns its head entry on rdata_second.
  - Combinational, zero latency.
  - Same-cycle commit writes do not count toward fl_num_i. This is conservative by design.
- Stall counter: increments when rename_valid_i & (state==IDLE) & !exception_i & (fl_num_i < need). It saturates at all-ones.
- Commit forwarding is combinational and honoured in every state:
  - fl_wr_first_en_o = commit_valid_first_i & commit_has_rd_first_i; same form for second.
  - fl_wdata_* pass the matching commit_old_prd_* through unchanged.
  - fl_rd_excep_*_en_o equal the matching fl_wr_*_en_o.
  - A commit coinciding with exception_i is forwarded in that cycle. excep_rst then follows at the next edge, so the freelist reloads its rd pointer from the updated exception pointer.
- Error detection:
  - err_o sets on the next edge if fl_num_i + wr_count - rd_count > FL_SIZE (overflow).
  - err_o sets on the next edge if rd_count > fl_num_i (underflow).
  - wr_count and rd_count are the number of asserted write and read enables this cycle.
  - Compute in FL_SIZE_WIDTH+2 bits.
  - err_o clears only on rst.
- Rename resumes at the first cycle with state==IDLE. If exception_i arrives at edge T, rename_ready_o can first be 1 in cycle T+2+RECOVER_CYCLES.

Test Plan:
- Reset: assert rst 2 cycles with all inputs 0 -> all outputs 0; stall_cnt_o=0; err_o=0.
- Dual allocation: fl_num_i=5, valid, need=2'b11 -> ready=1, both rd enables 1. need=2'b10 -> only fl_rd_second_en_o=1.
- Starvation: fl_num_i=1, need=2'b11, valid held 4 cycles -> ready=0, no rd enables, stall_cnt_o=4. Raising fl_num_i to 2 -> fire; counter holds at 4.
- Commit forwarding: commit slot1 only with has_rd, old_prd=6'd37 -> fl_wr_second_en_o=1, fl_wdata_second_o=37, fl_rd_excep_second_en_o=1, first-slot enables 0.
- Exception: RECOVER_CYCLES=2, exception_i at cycle T together with a dual commit:
  - Cycle T: commit forwarded, ready=0.
  - Cycle T+1: fl_excep_rst_o=1.
  - Cycles T+1..T+3: busy=1.
  - Cycle T+4: ready=1.
  - A second exception at T+2 -> fl_excep_rst_o=1 at T+3, and ready is delayed to T+6.
- Overflow: fl_num_i=31, dual commit writes with no reads -> err_o=1 the next cycle and stays 1 until rst.

Source files
------------

// File: rtl/rcu_freelist_ctrl_if.sv
// Rename, commit and freelist signals that connect the RCU pipeline to the
// 2-wide physical-register freelist through rcu_freelist_ctrl.
interface rcu_freelist_ctrl_if #(
   parameter int FL_SIZE_WIDTH = 5,
   parameter int PREG_WIDTH    = 6
);
   // rename-side handshake
   logic                       rename_valid_i;
   logic                       rename_need_first_i;
   logic                       rename_need_second_i;
   logic                       rename_ready_o;

   // freelist occupancy and allocation reads
   logic [FL_SIZE_WIDTH:0]     fl_num_i;
   logic                       fl_rd_first_en_o;
   logic                       fl_rd_second_en_o;

   // commit-side reclaim
   logic                       commit_valid_first_i;
   logic                       commit_valid_second_i;
   logic                       commit_has_rd_first_i;
   logic                       commit_has_rd_second_i;
   logic [PREG_WIDTH-1:0]      commit_old_prd_first_i;
   logic [PREG_WIDTH-1:0]      commit_old_prd_second_i;

   // freelist writes and exception-pointer advance
   logic                       fl_wr_first_en_o;
   logic                       fl_wr_second_en_o;
   logic [PREG_WIDTH-1:0]      fl_wdata_first_o;
   logic [PREG_WIDTH-1:0]      fl_wdata_second_o;
   logic                       fl_rd_excep_first_en_o;
   logic                       fl_rd_excep_second_en_o;

   // controller side
   modport slave (
      input  rename_valid_i, rename_need_first_i, rename_need_second_i,
      input  fl_num_i,
      input  commit_valid_first_i, commit_valid_second_i,
      input  commit_has_rd_first_i, commit_has_rd_second_i,
      input  commit_old_prd_first_i, commit_old_prd_second_i,
      output rename_ready_o,
      output fl_rd_first_en_o, fl_rd_second_en_o,
      output fl_wr_first_en_o, fl_wr_second_en_o,
      output fl_wdata_first_o, fl_wdata_second_o,
      output fl_rd_excep_first_en_o, fl_rd_excep_second_en_o
   );

   // pipeline / freelist side
   modport master (
      output rename_valid_i, rename_need_first_i, rename_need_second_i,
      output fl_num_i,
      output commit_valid_first_i, commit_valid_second_i,
      output commit_has_rd_first_i, commit_has_rd_second_i,
      output commit_old_prd_first_i, commit_old_prd_second_i,
      input  rename_ready_o,
      input  fl_rd_first_en_o, fl_rd_second_en_o,
      input  fl_wr_first_en_o, fl_wr_second_en_o,
      input  fl_wdata_first_o, fl_wdata_second_o,
      input  fl_rd_excep_first_en_o, fl_rd_excep_second_en_o
   );
endinterface

// File: rtl/rcu_freelist_ctrl.sv
// Sequencing controller for the 2-wide physical-register freelist.
// Gates rename allocation on freelist occupancy, forwards commit reclaims,
// and runs the exception-recovery sequence (one-cycle excep_rst, then a
// settle window with rename blocked).
module rcu_freelist_ctrl #(
   parameter int FL_SIZE         = 31,
   parameter int FL_SIZE_WIDTH   = 5,
   parameter int PREG_WIDTH      = 6,
   parameter int RECOVER_CYCLES  = 2,
   parameter int STALL_CNT_WIDTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   rcu_freelist_ctrl_if.slave         fl_if,
   input  logic                       exception_i,
   output logic                       fl_excep_rst_o,
   output logic                       recover_busy_o,
   output logic [STALL_CNT_WIDTH-1:0] stall_cnt_o,
   output logic                       err_o
);

   localparam int CNT_W = FL_SIZE_WIDTH + 2;
   localparam logic [3:0]       SETTLE_LOAD = 4'(RECOVER_CYCLES - 1);
   localparam logic [CNT_W-1:0] FL_SIZE_EXT = CNT_W'(FL_SIZE);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FLUSH  = 2'd1,
      SETTLE = 2'd2
   } state_e;

   state_e                     state_q, state_d;
   logic [3:0]                 settle_q, settle_d;
   logic [STALL_CNT_WIDTH-1:0] stall_q, stall_d;
   logic                       err_q, err_d;

   logic [1:0]                 need;
   logic                       enough;
   logic                       alloc_open;
   logic                       fire;
   logic                       starved;
   logic                       rd_first, rd_second;
   logic                       wr_first, wr_second;
   logic [CNT_W-1:0]           num_ext, wr_cnt, rd_cnt, level;
   logic                       overflow, underflow;

   // Recovery state and settle counter register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         settle_q <= '0;
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
      end
   end

   // Recovery sequence: IDLE -> FLUSH -> SETTLE(n) -> IDLE; any exception restarts at FLUSH
   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      unique case (state_q)
         IDLE: begin
            if (exception_i) state_d = FLUSH;
         end
         FLUSH: begin
            if (exception_i) begin
               state_d = FLUSH;
            end else begin
               state_d  = SETTLE;
               settle_d = SETTLE_LOAD;
            end
         end
         SETTLE: begin
            if (exception_i) begin
               state_d = FLUSH;
            end else if (settle_q == 4'd0) begin
               state_d = IDLE;
            end else begin
               settle_d = settle_q - 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Allocation gating; rst forces ready low so nothing is granted during reset
   always_comb begin
      need       = {1'b0, fl_if.rename_need_first_i} + {1'b0, fl_if.rename_need_second_i};
      enough     = (fl_if.fl_num_i >= {{(FL_SIZE_WIDTH-1){1'b0}}, need});
      alloc_open = (state_q == IDLE) && !exception_i && !rst;
      fire       = fl_if.rename_valid_i && alloc_open && enough;
      starved    = fl_if.rename_valid_i && (state_q == IDLE) && !exception_i && !enough;
      rd_first   = fire && fl_if.rename_need_first_i;
      rd_second  = fire && fl_if.rename_need_second_i;
   end

   // Commit reclaim forwarding, honoured in every recovery state
   always_comb begin
      wr_first  = fl_if.commit_valid_first_i  && fl_if.commit_has_rd_first_i;
      wr_second = fl_if.commit_valid_second_i && fl_if.commit_has_rd_second_i;
   end

   assign fl_if.rename_ready_o          = alloc_open && enough;
   assign fl_if.fl_rd_first_en_o        = rd_first;
   assign fl_if.fl_rd_second_en_o       = rd_second;
   assign fl_if.fl_wr_first_en_o        = wr_first;
   assign fl_if.fl_wr_second_en_o       = wr_second;
   assign fl_if.fl_wdata_first_o        = fl_if.commit_old_prd_first_i;
   assign fl_if.fl_wdata_second_o       = fl_if.commit_old_prd_second_i;
   assign fl_if.fl_rd_excep_first_en_o  = wr_first;
   assign fl_if.fl_rd_excep_second_en_o = wr_second;
   assign fl_excep_rst_o                = (state_q == FLUSH);
   assign recover_busy_o                = (state_q != IDLE);

   // Occupancy sanity check; an underflow also wraps the level past FL_SIZE
   always_comb begin
      num_ext   = {1'b0, fl_if.fl_num_i};
      wr_cnt    = CNT_W'(wr_first) + CNT_W'(wr_second);
      rd_cnt    = CNT_W'(rd_first) + CNT_W'(rd_second);
      level     = num_ext + wr_cnt - rd_cnt;
      overflow  = (level > FL_SIZE_EXT);
      underflow = (rd_cnt > num_ext);
      err_d     = err_q || overflow || underflow;
   end

   // Saturating count of freelist-starved rename cycles
   always_comb begin
      stall_d = stall_q;
      if (starved && (stall_q != {STALL_CNT_WIDTH{1'b1}})) stall_d = stall_q + 1'b1;
   end

   // Stall counter and sticky error register
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= '0;
         err_q   <= 1'b0;
      end else begin
         stall_q <= stall_d;
         err_q   <= err_d;
      end
   end

   assign stall_cnt_o = stall_q;
   assign err_o       = err_q;

endmodule
